// File: rtl/ifetch_buffer.sv
// Instruction-fetch buffer: issues PC-stage fetches to instruction memory, collects in-order
// responses of variable latency into a ring, and hands them to decode in program order.
// A flush empties the ring and counts the still-in-flight responses so they are dropped.
module ifetch_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_valid,
  input  logic [31:0] pc_in,
  output logic        pc_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault,
  input  logic        out_ready
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = IW + 1;

  typedef logic [PW-1:0] ptr_t;

  localparam logic [PW:0] DepthW = (PW + 1)'(DEPTH);

  ptr_t alloc_ptr_q, alloc_ptr_d;
  ptr_t resp_ptr_q, resp_ptr_d;
  ptr_t head_ptr_q, head_ptr_d;
  ptr_t drop_cnt_q, drop_cnt_d;

  logic [31:0] pc_q    [DEPTH];
  logic [31:0] pc_d    [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [31:0] instr_d [DEPTH];
  logic        fault_q [DEPTH];
  logic        fault_d [DEPTH];
  logic        done_q  [DEPTH];
  logic        done_d  [DEPTH];

  ptr_t          alloc_cnt;
  ptr_t          outstanding;
  logic [PW:0]   credit_sum;
  logic          credit_ok;
  logic          grant;
  logic          pop;
  logic          drop_hit;
  logic          resp_take;
  logic          rv_consumed;
  logic [IW-1:0] alloc_idx;
  logic [IW-1:0] resp_idx;
  logic [IW-1:0] head_idx;

  // Handshake and output decode from registered state and current inputs.
  always_comb begin
    alloc_idx   = alloc_ptr_q[IW-1:0];
    resp_idx    = resp_ptr_q[IW-1:0];
    head_idx    = head_ptr_q[IW-1:0];
    alloc_cnt   = alloc_ptr_q - head_ptr_q;
    outstanding = alloc_ptr_q - resp_ptr_q;
    // Entries awaiting a dropped response still occupy memory-side credit.
    credit_sum  = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};
    credit_ok   = credit_sum < DepthW;
    imem_req    = pc_valid && credit_ok && !flush && !reset;
    imem_addr   = {pc_in[31:2], 2'b00};
    grant       = imem_req && imem_gnt;
    pc_ready    = grant;
    out_valid   = (alloc_cnt != '0) && done_q[head_idx] && !flush;
    out_pc      = pc_q[head_idx];
    out_instr   = instr_q[head_idx];
    out_fault   = fault_q[head_idx];
    pop         = out_valid && out_ready;
    drop_hit    = imem_rvalid && (drop_cnt_q != '0);
    resp_take   = imem_rvalid && (drop_cnt_q == '0) && (outstanding != '0) && !flush;
    // A response arriving in the flush cycle retires one pending drop or in-flight fetch.
    rv_consumed = imem_rvalid && ((drop_cnt_q != '0) || (outstanding != '0));
  end

  // Next-state for pointers, drop counter and ring contents.
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    resp_ptr_d  = resp_ptr_q;
    head_ptr_d  = head_ptr_q;
    drop_cnt_d  = drop_cnt_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    fault_d     = fault_q;
    done_d      = done_q;
    if (flush) begin
      head_ptr_d = alloc_ptr_q;
      resp_ptr_d = alloc_ptr_q;
      drop_cnt_d = drop_cnt_q + outstanding - ptr_t'(rv_consumed);
    end else begin
      if (grant) begin
        pc_d[alloc_idx]   = pc_in;
        done_d[alloc_idx] = 1'b0;
        alloc_ptr_d       = alloc_ptr_q + ptr_t'(1);
      end
      if (drop_hit) begin
        drop_cnt_d = drop_cnt_q - ptr_t'(1);
      end else if (resp_take) begin
        instr_d[resp_idx] = imem_rdata;
        fault_d[resp_idx] = imem_err;
        done_d[resp_idx]  = 1'b1;
        resp_ptr_d        = resp_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        head_ptr_d = head_ptr_q + ptr_t'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr_q <= '0;
      resp_ptr_q  <= '0;
      head_ptr_q  <= '0;
      drop_cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
        fault_q[i] <= 1'b0;
        done_q[i]  <= 1'b0;
      end
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      resp_ptr_q  <= resp_ptr_d;
      head_ptr_q  <= head_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      fault_q     <= fault_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed, table-driven bench for ifetch_buffer: one row per clock cycle of inputs and the
// outputs expected in that cycle, plus a hand-written steady-state streaming sequence.
module tb_ifetch_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        pc_valid;
  logic [31:0] pc_in;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic        out_ready;

  ifetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_valid   (pc_valid),
    .pc_in      (pc_in),
    .pc_ready   (pc_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .imem_err   (imem_err),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_fault  (out_fault),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [31:0] pc;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        err;
    logic        fl;
    logic        ordy;
    logic        ereq;
    logic        eov;
    logic [31:0] epc;
    logic [31:0] ein;
    logic        ef;
    logic        chk;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] ins(input logic [31:0] p);
    return 32'hA500_0000 ^ p;
  endfunction

  function automatic logic [31:0] junk(input logic [31:0] p);
    return 32'hDEAD_0000 | p;
  endfunction

  function automatic void r(input logic rst, input logic pv, input logic [31:0] pc,
                            input logic gnt, input logic rv, input logic [31:0] rd,
                            input logic err, input logic fl, input logic ordy,
                            input logic ereq, input logic eov, input logic [31:0] epc,
                            input logic [31:0] ein, input logic ef, input logic chk);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pc = pc; v.gnt = gnt; v.rv = rv; v.rd = rd; v.err = err;
    v.fl = fl; v.ordy = ordy; v.ereq = ereq; v.eov = eov; v.epc = epc; v.ein = ein;
    v.ef = ef; v.chk = chk;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic pv, input logic [31:0] pc, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic err, input logic fl,
                       input logic ordy);
    reset = rst; pc_valid = pv; pc_in = pc; imem_gnt = gnt; imem_rvalid = rv;
    imem_rdata = rd; imem_err = err; flush = fl; out_ready = ordy;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    // rst pv pc gnt rv rdata err fl ordy | ereq eov epc ein ef chk
    // Reset state, with pc_valid/gnt held high to show the request is masked.
    r(1, 1, 32'h0, 1, 0, 0, 0, 0, 0,  0, 0, 32'h0, 32'h0, 0, 1);
    // Back-to-back streaming, bus error on PC 0x8.
    r(0, 1, 32'h0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h4, 1, 1, ins(32'h0), 0, 0, 0,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h8, 1, 1, ins(32'h4), 0, 0, 1,  1, 1, 32'h0, ins(32'h0), 0, 0);
    r(0, 1, 32'hC, 1, 1, ins(32'h8), 1, 0, 1,  1, 1, 32'h4, ins(32'h4), 0, 0);
    r(0, 0, 32'h0, 0, 1, ins(32'hC), 0, 0, 1,  0, 1, 32'h8, ins(32'h8), 1, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 1, 32'hC, ins(32'hC), 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    // Backpressure: four grants fill the ring, a one-cycle pop admits exactly one more.
    r(0, 1, 32'h10, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h14, 1, 1, ins(32'h10), 0, 0, 0,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h18, 1, 1, ins(32'h14), 0, 0, 0,  1, 1, 32'h10, ins(32'h10), 0, 0);
    r(0, 1, 32'h1C, 1, 1, ins(32'h18), 0, 0, 0,  1, 1, 32'h10, ins(32'h10), 0, 0);
    r(0, 1, 32'h23, 1, 1, ins(32'h1C), 0, 0, 0,  0, 1, 32'h10, ins(32'h10), 0, 0);
    r(0, 1, 32'h23, 1, 0, 0, 0, 0, 1,  0, 1, 32'h10, ins(32'h10), 0, 0);
    r(0, 1, 32'h20, 1, 0, 0, 0, 0, 0,  1, 1, 32'h14, ins(32'h14), 0, 0);
    r(0, 1, 32'h24, 1, 0, 0, 0, 0, 0,  0, 1, 32'h14, ins(32'h14), 0, 0);
    r(0, 0, 32'h0, 0, 1, ins(32'h20), 0, 0, 1,  0, 1, 32'h14, ins(32'h14), 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h18, ins(32'h18), 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h1C, ins(32'h1C), 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h20, ins(32'h20), 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    // Variable latency responses.
    r(0, 1, 32'h40, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h44, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h48, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 1, ins(32'h40), 0, 0, 1,  0, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 1, ins(32'h44), 0, 0, 1,  0, 1, 32'h40, ins(32'h40), 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h44, ins(32'h44), 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 1, ins(32'h48), 0, 0, 1,  0, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h48, ins(32'h48), 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    // Flush with three outstanding; new fetch right after; drops hold back credit.
    r(0, 1, 32'h60, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h64, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h68, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h100, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
    r(0, 1, 32'h100, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h104, 1, 1, junk(32'h60), 0, 0, 1,  0, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 1, junk(32'h64), 0, 0, 1,  0, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 1, junk(32'h68), 0, 0, 1,  0, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 1, ins(32'h100), 0, 0, 1,  0, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h100, ins(32'h100), 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    // Flush coinciding with rvalid, two outstanding and a ready head entry.
    r(0, 1, 32'h80, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h84, 1, 1, ins(32'h80), 0, 0, 0,  1, 0, 0, 0, 0, 0);
    r(0, 1, 32'h88, 1, 0, 0, 0, 0, 0,  1, 1, 32'h80, ins(32'h80), 0, 0);
    r(0, 1, 32'h90, 1, 1, junk(32'h84), 0, 1, 1,  0, 0, 0, 0, 0, 0);
    r(0, 1, 32'h200, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 1, junk(32'h88), 0, 0, 1,  0, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 1, ins(32'h200), 0, 0, 1,  0, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 1, 32'h200, ins(32'h200), 0, 0);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    // Reset with an entry buffered.
    r(0, 1, 32'h300, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    r(0, 0, 32'h0, 0, 1, ins(32'h300), 1, 0, 0,  0, 0, 0, 0, 0, 0);
    r(1, 1, 32'h304, 1, 0, 0, 0, 0, 0,  0, 1, 32'h300, ins(32'h300), 1, 1);
    r(0, 0, 32'h0, 0, 0, 0, 0, 0, 0,  0, 0, 32'h0, 32'h0, 0, 1);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      drive(v.rst, v.pv, v.pc, v.gnt, v.rv, v.rd, v.err, v.fl, v.ordy);
      #1;
      check($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, v.ereq});
      check($sformatf("row%0d pc_ready", i), {31'b0, pc_ready}, {31'b0, v.ereq & v.gnt});
      if (v.pv) check($sformatf("row%0d imem_addr", i), imem_addr, v.pc & 32'hFFFF_FFFC);
      check($sformatf("row%0d out_valid", i), {31'b0, out_valid}, {31'b0, v.eov});
      if (v.eov || v.chk) begin
        check($sformatf("row%0d out_pc", i), out_pc, v.epc);
        check($sformatf("row%0d out_instr", i), out_instr, v.ein);
        check($sformatf("row%0d out_fault", i), {31'b0, out_fault}, {31'b0, v.ef});
      end
    end

    // Steady state: grant, response and pop all in the same cycle.
    for (int k = 0; k < 12; k++) begin
      logic [31:0] prev_pc;
      logic [31:0] head_pc;
      prev_pc = 32'h600 + 32'(4 * (k - 1));
      head_pc = 32'h600 + 32'(4 * (k - 2));
      @(negedge clk);
      drive(0, k < 10, 32'h600 + 32'(4 * k), k < 10, k >= 1 && k < 11,
            ins(prev_pc), 0, 0, 1);
      #1;
      check($sformatf("stream%0d imem_req", k), {31'b0, imem_req}, {31'b0, k < 10});
      check($sformatf("stream%0d out_valid", k), {31'b0, out_valid}, {31'b0, k >= 2});
      if (k >= 2) begin
        check($sformatf("stream%0d out_pc", k), out_pc, head_pc);
        check($sformatf("stream%0d out_instr", k), out_instr, ins(head_pc));
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("stream drained out_valid", {31'b0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
